// File: rtl/nibble_pair_demux.sv
// -----------------------------------------------------------------------------
// nibble_pair_demux
//
// Receiving end of the time-multiplexed nibble bus. Lane-A and lane-B values
// arrive alternately on one W-bit bus, tagged by in_sel. They are captured
// into separate holding registers and, once both lanes are present, offered
// downstream as one pair under a valid/ready handshake. Backpressure reaches
// the bus source through in_ready.
//
// Parameters
//   W          data width of the bus and of each lane register (default 4)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active low
//   in_valid   in   bus source presents a nibble
//   in_sel     in   lane tag: 0 = lane A, 1 = lane B
//   in_data    in   nibble on the bus
//   in_ready   out  block accepts a nibble this cycle
//   out_valid  out  out_a/out_b hold a complete pair
//   out_ready  in   consumer accepts the pair
//   out_a      out  captured lane-A value
//   out_b      out  captured lane-B value
//   err        out  sticky lane-overwrite flag
//
// Build option
//   NIBBLE_PAIR_ORDER_CHECK_EN  when defined, err sets on any push that
//   overwrites a lane already held while waiting for the other lane, and
//   stays set until rst_n is asserted. When undefined, err is tied low.
// -----------------------------------------------------------------------------
module nibble_pair_demux #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         in_sel,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic         err
);

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        HAVE_A = 2'b01,
        HAVE_B = 2'b10,
        FULL   = 2'b11
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic           push_s;
    logic           pop_s;
    logic           load_a_s;
    logic           load_b_s;

    // Handshake decode: in_ready only depends on out_ready combinationally,
    // so a pair can drain and a new nibble land in the same cycle.
    assign in_ready  = (state_r != FULL) | out_ready;
    assign out_valid = (state_r == FULL);
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;
    assign out_a     = a_r;
    assign out_b     = b_r;

    // Next-state and lane-load decode.
    always_comb begin
        state_s  = state_r;
        load_a_s = 1'b0;
        load_b_s = 1'b0;
        case (state_r)
            EMPTY: begin
                if (push_s) begin
                    if (in_sel) begin
                        load_b_s = 1'b1;
                        state_s  = HAVE_B;
                    end else begin
                        load_a_s = 1'b1;
                        state_s  = HAVE_A;
                    end
                end else begin
                    state_s = EMPTY;
                end
            end
            HAVE_A: begin
                if (push_s) begin
                    if (in_sel) begin
                        load_b_s = 1'b1;
                        state_s  = FULL;
                    end else begin
                        // Same lane again: latest value wins.
                        load_a_s = 1'b1;
                        state_s  = HAVE_A;
                    end
                end else begin
                    state_s = HAVE_A;
                end
            end
            HAVE_B: begin
                if (push_s) begin
                    if (in_sel) begin
                        load_b_s = 1'b1;
                        state_s  = HAVE_B;
                    end else begin
                        load_a_s = 1'b1;
                        state_s  = FULL;
                    end
                end else begin
                    state_s = HAVE_B;
                end
            end
            FULL: begin
                if (pop_s) begin
                    // Pop and push overlap: the new nibble starts the next pair.
                    if (push_s) begin
                        if (in_sel) begin
                            load_b_s = 1'b1;
                            state_s  = HAVE_B;
                        end else begin
                            load_a_s = 1'b1;
                            state_s  = HAVE_A;
                        end
                    end else begin
                        state_s = EMPTY;
                    end
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = EMPTY;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Lane holding registers; each written only on a push to its own lane,
    // otherwise holding a possibly stale value that out_valid qualifies.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r <= {W{1'b0}};
            b_r <= {W{1'b0}};
        end else begin
            if (load_a_s) begin
                a_r <= in_data;
            end else begin
                a_r <= a_r;
            end
            if (load_b_s) begin
                b_r <= in_data;
            end else begin
                b_r <= b_r;
            end
        end
    end

`ifdef NIBBLE_PAIR_ORDER_CHECK_EN
    logic err_r;
    logic overwrite_s;

    // A push to the lane already held while waiting for the other lane.
    assign overwrite_s = push_s &
                         (((state_r == HAVE_A) & ~in_sel) |
                          ((state_r == HAVE_B) &  in_sel));

    // Sticky overwrite flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (overwrite_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_pair_demux.sv
module tb_nibble_pair_demux;

    localparam int W = 4;
`ifdef NIBBLE_PAIR_ORDER_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_sel;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic         err;

    int total;
    int bad;

    // expected pairs {a,b}, pushed by stimulus, popped by the monitor
    logic [2*W-1:0] exp_q[$];

    nibble_pair_demux #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present a nibble, wait (bounded) for in_ready, commit on the next edge.
    task automatic push(input logic sel, input logic [W-1:0] data);
        int waited;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        waited   = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 20) check("push_ready_timeout", 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // One-cycle consumer accept.
    task automatic pop_pulse();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    // Monitor: every presented pair is compared with the scoreboard head;
    // the entry retires only when the consumer accepts it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pair", {24'd0, out_a, out_b}, 32'hFFFF_FFFF);
                end else begin
                    check("pair", {24'd0, out_a, out_b}, {24'd0, exp_q[0]});
                    if (out_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 1'b0;
        in_data   = 4'hF;
        out_ready = 1'b0;

        // reset with in_valid asserted
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_a", {28'd0, out_a}, 32'd0);
        check("rst_out_b", {28'd0, out_b}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // A then B, held under backpressure
        push(1'b0, 4'h3);
        exp_q.push_back(8'h3C);
        push(1'b1, 4'hC);
        @(negedge clk);
        check("ab_out_valid", {31'd0, out_valid}, 32'd1);
        check("ab_in_ready", {31'd0, in_ready}, 32'd0);
        idle(5);
        @(negedge clk);
        check("ab_hold_valid", {31'd0, out_valid}, 32'd1);
        check("ab_hold_a", {28'd0, out_a}, 32'h3);
        check("ab_hold_b", {28'd0, out_b}, 32'hC);
        @(posedge clk);
        #1;
        pop_pulse();
        @(negedge clk);
        check("ab_after_pop_valid", {31'd0, out_valid}, 32'd0);

        // B then A, then pop
        @(posedge clk);
        #1;
        push(1'b1, 4'h9);
        exp_q.push_back(8'h59);
        push(1'b0, 4'h5);
        @(negedge clk);
        check("ba_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        pop_pulse();
        @(negedge clk);
        check("ba_pop_valid", {31'd0, out_valid}, 32'd0);
        check("ba_pop_in_ready", {31'd0, in_ready}, 32'd1);

        // overlapped pop + push in FULL
        @(posedge clk);
        #1;
        push(1'b0, 4'h1);
        exp_q.push_back(8'h12);
        push(1'b1, 4'h2);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 1'b0;
        in_data   = 4'h7;
        @(negedge clk);
        check("ovl_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("ovl_out_valid", {31'd0, out_valid}, 32'd0);
        check("ovl_out_a", {28'd0, out_a}, 32'h7);
        @(posedge clk);
        #1;
        exp_q.push_back(8'h78);
        push(1'b1, 4'h8);
        @(negedge clk);
        check("ovl2_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        pop_pulse();

        // same-lane overwrite
        check("pre_ow_err", {31'd0, err}, 32'd0);
        push(1'b0, 4'h1);
        push(1'b0, 4'h4);
        exp_q.push_back(8'h46);
        push(1'b1, 4'h6);
        @(negedge clk);
        check("ow_err", {31'd0, err}, {31'd0, CHK_EN});
        check("ow_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        pop_pulse();
        idle(3);
        @(negedge clk);
        check("ow_err_sticky", {31'd0, err}, {31'd0, CHK_EN});

        // reset in HAVE_A
        @(posedge clk);
        #1;
        push(1'b0, 4'hA);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_out_a", {28'd0, out_a}, 32'h0);
        check("mrst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        // a lone B must not complete a pair if the A was truly discarded
        push(1'b1, 4'hD);
        @(negedge clk);
        check("mrst_half_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(8'h2D);
        push(1'b0, 4'h2);
        @(negedge clk);
        check("mrst_pair_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        pop_pulse();
        idle(2);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
